// File: rtl/x_top_uart_loader_pkg.sv
// Shared types and constants for the UART loader command sequencer.
//   loader_state_t : sequencer states (IDLE, ADDR, DATA, ISSUE)
//   loader_err_t   : error cause codes reported on o_err_code
//   BYTE_CNT_TOP   : index of the last byte in a 4-byte address/data field
package x_top_uart_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    ISSUE = 2'd3
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CMD     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } loader_err_t;

  localparam logic [1:0] BYTE_CNT_TOP = 2'd3;

endpackage

// File: rtl/x_top_timeout.sv
// Clear/enable up-counter with a terminal-count flag, used as an idle timer
// by UART-side blocks.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (count -> 0)
//   i_clr  : synchronous clear (count -> 0), wins over i_en
//   i_en   : advance the count by one
//   o_tc   : high while the count equals p_max-1
// The counter is $clog2(p_max) bits wide; users clear it at terminal count so
// it never needs to represent p_max itself.
module x_top_timeout #(
  parameter int p_max = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = (p_max > 2) ? $clog2(p_max) : 1;
  localparam logic [W-1:0] TC = W'(p_max - 1);

  logic [W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      count <= '0;
    end else if (i_en) begin
      count <= count + 1'b1;
    end
  end

  assign o_tc = (count == TC);

endmodule

// File: rtl/x_top_uart_loader.sv
// UART loader command sequencer. Parses the received byte stream into write
// frames (command byte, 4-byte address, 4-byte data, both little-endian) and
// issues one write request per frame.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_valid/i_data : one-cycle received-byte strobe and byte
//   o_wr_valid/i_wr_ready/o_wr_addr/o_wr_data : write request port
//   o_busy         : high whenever the sequencer is not IDLE
//   o_err          : one-cycle error pulse; o_err_code holds the last cause
//   o_dbg_state    : current sequencer state, for observation only
//
// Write port handshake: o_wr_valid rises the cycle after the last data byte
// and stays high, with o_wr_addr/o_wr_data stable, until a cycle in which
// i_wr_ready is also high; that cycle completes the transfer and o_wr_valid
// drops on the next edge. Address/data are not cleared after the transfer.
module x_top_uart_loader
  import x_top_uart_loader_pkg::*;
#(
  parameter logic [7:0] p_cmd_write = 8'hA5,
  parameter int         p_timeout   = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_busy,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic [1:0]  o_dbg_state
);

  loader_state_t state;
  logic [1:0]    cnt;
  logic          timing;
  logic          timer_tc;

  // The inter-byte timer only runs while a frame is being received. It is
  // held at zero elsewhere, so it enters ADDR already cleared, and every
  // accepted byte restarts it. Clearing on terminal count keeps it in range.
  assign timing = (state == ADDR) || (state == DATA);

  x_top_timeout #(
    .p_max (p_timeout)
  ) u_timeout (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (!timing || i_valid || timer_tc),
    .i_en  (1'b1),
    .o_tc  (timer_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= 32'd0;
      o_wr_data  <= 32'd0;
      o_err      <= 1'b0;
      o_err_code <= ERR_NONE;
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (i_data == p_cmd_write) begin
              state <= ADDR;
              cnt   <= 2'd0;
            end else begin
              o_err      <= 1'b1;
              o_err_code <= ERR_CMD;
            end
          end
        end

        // An arriving byte takes priority over a coincident timeout.
        ADDR: begin
          if (i_valid) begin
            o_wr_addr <= {i_data, o_wr_addr[31:8]};
            if (cnt == BYTE_CNT_TOP) begin
              cnt   <= 2'd0;
              state <= DATA;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end else if (timer_tc) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            o_err      <= 1'b1;
            o_err_code <= ERR_TIMEOUT;
          end
        end

        DATA: begin
          if (i_valid) begin
            o_wr_data <= {i_data, o_wr_data[31:8]};
            if (cnt == BYTE_CNT_TOP) begin
              cnt        <= 2'd0;
              state      <= ISSUE;
              o_wr_valid <= 1'b1;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end else if (timer_tc) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            o_err      <= 1'b1;
            o_err_code <= ERR_TIMEOUT;
          end
        end

        // o_wr_valid is always high here. A byte arriving now is dropped as
        // an overrun, even if the handshake completes in the same cycle.
        ISSUE: begin
          if (i_valid) begin
            o_err      <= 1'b1;
            o_err_code <= ERR_OVERRUN;
          end
          if (i_wr_ready) begin
            o_wr_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy      = (state != IDLE);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_x_top_uart_loader.sv
module tb_x_top_uart_loader;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        o_wr_valid;
  logic        i_wr_ready = 1'b0;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_busy;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int valid_cycles = 0;

  logic [63:0] exp_q[$];

  x_top_uart_loader #(
    .p_cmd_write (8'hA5),
    .p_timeout   (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_wr_valid  (o_wr_valid),
    .i_wr_ready  (i_wr_ready),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_err_code  (o_err_code),
    .o_dbg_state (o_dbg_state)
  );

  // clock
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every completed handshake must match the oldest expected frame
  always @(negedge i_clk) begin
    if (!i_rst && o_wr_valid) valid_cycles++;
    if (!i_rst && o_wr_valid && i_wr_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", {o_wr_addr, o_wr_data}, 64'hx);
      end else begin
        check("xfer_addr_data", {o_wr_addr, o_wr_data}, exp_q.pop_front());
      end
    end
  end

  // drivers: inputs change 1 time unit after the active edge
  task automatic send_byte(input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  initial begin
    // reset
    repeat (2) tick();
    i_rst = 1'b0;
    check("rst_wr_valid", {63'd0, o_wr_valid}, 64'd0);
    check("rst_addr_data", {o_wr_addr, o_wr_data}, 64'd0);
    check("rst_err", {60'd0, o_err, o_err_code, o_busy}, 64'd0);
    check("rst_state", {62'd0, o_dbg_state}, 64'd0);

    // 1: basic frame, ready high
    i_wr_ready = 1'b1;
    valid_cycles = 0;
    exp_q.push_back({32'h12345678, 32'hDEADBEEF});
    send_byte(8'hA5);
    check("busy_after_cmd", {63'd0, o_busy}, 64'd1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    check("t1_valid_rise", {63'd0, o_wr_valid}, 64'd1);
    check("t1_addr", {32'd0, o_wr_addr}, {32'd0, 32'h12345678});
    check("t1_data", {32'd0, o_wr_data}, {32'd0, 32'hDEADBEEF});
    tick();
    check("t1_valid_fall", {63'd0, o_wr_valid}, 64'd0);
    check("t1_busy_low", {63'd0, o_busy}, 64'd0);
    check("t1_valid_cycles", 64'(valid_cycles), 64'd1);
    check("t1_xfers", 64'(n_xfer), 64'd1);

    // 2: ready held low 10 cycles after valid rises
    i_wr_ready = 1'b0;
    valid_cycles = 0;
    exp_q.push_back({32'h12345678, 32'hDEADBEEF});
    send_frame(32'h12345678, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      check("t2_hold", {o_wr_addr, o_wr_data}, {32'h12345678, 32'hDEADBEEF});
      tick();
    end
    check("t2_still_valid", {63'd0, o_wr_valid}, 64'd1);
    i_wr_ready = 1'b1;
    tick();
    i_wr_ready = 1'b0;
    check("t2_valid_fall", {63'd0, o_wr_valid}, 64'd0);
    check("t2_valid_cycles", 64'(valid_cycles), 64'd11);
    check("t2_xfers", 64'(n_xfer), 64'd2);

    // 3: bad command in IDLE
    send_byte(8'h3C);
    check("t3_err_pulse", {62'd0, o_err, 1'b0}, {62'd0, 2'b10});
    check("t3_err_code", {62'd0, o_err_code}, 64'd1);
    check("t3_state_idle", {61'd0, o_busy, o_dbg_state}, 64'd0);
    tick();
    check("t3_err_one_cycle", {63'd0, o_err}, 64'd0);
    check("t3_code_held", {62'd0, o_err_code}, 64'd1);
    i_wr_ready = 1'b1;
    exp_q.push_back({32'hA1B2C3D4, 32'h0BADF00D});
    send_frame(32'hA1B2C3D4, 32'h0BADF00D);
    tick();
    check("t3_xfers", 64'(n_xfer), 64'd3);

    // 4: timeout after A5 01 02 (p_timeout = 16)
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    repeat (15) tick();
    check("t4_no_err_early", {62'd0, o_err, o_busy}, 64'd1);
    tick();
    check("t4_err_pulse", {63'd0, o_err}, 64'd1);
    check("t4_err_code", {62'd0, o_err_code}, 64'd2);
    check("t4_busy_low", {61'd0, o_busy, o_dbg_state}, 64'd0);
    tick();
    check("t4_err_one_cycle", {63'd0, o_err}, 64'd0);
    exp_q.push_back({32'h0000BEEF, 32'h11223344});
    send_frame(32'h0000BEEF, 32'h11223344);
    tick();
    check("t4_xfers", 64'(n_xfer), 64'd4);

    // 4b: byte arrives exactly at timer == 15 and wins
    exp_q.push_back({32'h44332211, 32'h88776655});
    send_byte(8'hA5); send_byte(8'h11);
    repeat (15) tick();
    send_byte(8'h22);
    check("t4b_no_err", {62'd0, o_err, o_busy}, 64'd1);
    check("t4b_code_unchanged", {62'd0, o_err_code}, 64'd2);
    send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    tick();
    check("t4b_xfers", 64'(n_xfer), 64'd5);

    // 5: overrun during ISSUE, then overrun coinciding with ready
    i_wr_ready = 1'b0;
    exp_q.push_back({32'hCAFEF00D, 32'h01234567});
    send_frame(32'hCAFEF00D, 32'h01234567);
    repeat (2) tick();
    send_byte(8'hA5);
    check("t5_err_pulse", {63'd0, o_err}, 64'd1);
    check("t5_err_code", {62'd0, o_err_code}, 64'd3);
    check("t5_still_valid", {63'd0, o_wr_valid}, 64'd1);
    check("t5_unchanged", {o_wr_addr, o_wr_data}, {32'hCAFEF00D, 32'h01234567});
    tick();
    i_wr_ready = 1'b1;
    send_byte(8'hA5);
    i_wr_ready = 1'b0;
    check("t5b_err_pulse", {63'd0, o_err}, 64'd1);
    check("t5b_err_code", {62'd0, o_err_code}, 64'd3);
    check("t5b_valid_fall", {63'd0, o_wr_valid}, 64'd0);
    check("t5b_state_idle", {61'd0, o_busy, o_dbg_state}, 64'd0);
    check("t5_xfers", 64'(n_xfer), 64'd6);

    // 6: reset mid-frame, then a clean frame
    i_wr_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'hAA); send_byte(8'hBB);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("t6_rst_addr_data", {o_wr_addr, o_wr_data}, 64'd0);
    check("t6_rst_ctrl", {59'd0, o_wr_valid, o_err, o_err_code, o_busy}, 64'd0);
    check("t6_rst_state", {62'd0, o_dbg_state}, 64'd0);
    exp_q.push_back({32'h01020304, 32'hF00DD00D});
    send_frame(32'h01020304, 32'hF00DD00D);
    tick();
    check("t6_xfers", 64'(n_xfer), 64'd7);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/x_top_uart_loader.md
Name: x_top_uart_loader

Overview:
Command sequencer that sits downstream of the UART receiver. It parses the received byte stream into write frames and drives a valid/ready write-request port toward the memory/bus side of the rv32i peripheral. Each frame is one command byte, a 4-byte address and a 4-byte data word, both little-endian. The block also handles inter-byte timeout, bad commands and overrun.

Parameters:
p_cmd_write, 8'hA5, command byte that opens a write frame
p_timeout, 100000, idle cycles allowed between bytes inside a frame (must be >= 2)

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  one-cycle pulse, received byte available
i_data  input  8  received byte, qualified by i_valid
o_wr_valid  output  1  write request valid
i_wr_ready  input  1  write request accepted when high with o_wr_valid
o_wr_addr  output  32  write address
o_wr_data  output  32  write data
o_busy  output  1  high in any state other than IDLE
o_err  output  1  one-cycle error pulse
o_err_code  output  2  error cause, held until next error: 1 bad command, 2 timeout, 3 overrun

Behaviour:
- Reset (i_rst high at a clock edge): state IDLE; byte count 0; timer 0; o_wr_valid 0; o_wr_addr 0; o_wr_data 0; o_err 0; o_err_code 0; o_busy 0. Reset wins over every other event, including mid-frame and mid-handshake; the partial frame is discarded.
- State machine: IDLE, ADDR, DATA, ISSUE.
- IDLE:
  - i_valid with i_data == p_cmd_write -> ADDR, count 0.
  - i_valid with any other byte -> stay IDLE; o_err pulses next cycle with code 1.
- ADDR: each i_valid shifts the byte in LSB-first (addr = {i_data, addr[31:8]}) and increments count. The 4th byte sets count to 0 and moves to DATA.
- DATA: same shift into data. The 4th byte moves to ISSUE.
- ISSUE:
  - o_wr_valid is high from the cycle after the 4th data byte's i_valid edge.
  - o_wr_addr and o_wr_data are stable while o_wr_valid is high.
  - On a cycle with o_wr_valid & i_wr_ready, the transfer completes: next cycle o_wr_valid = 0, state IDLE.
  - No timeout applies in ISSUE; the block waits indefinitely for ready.
- Overrun: i_valid in ISSUE drops the byte; o_err pulses with code 3. This holds even when the handshake completes in the same cycle; the byte is not treated as a new command.
- Timeout:
  - The timer runs only in ADDR and DATA. It clears to 0 on entering those states and on every accepted byte, and otherwise increments.
  - When the timer reaches p_timeout-1 with no i_valid, the next state is IDLE; o_err pulses with code 2 and count clears.
  - If i_valid and timer == p_timeout-1 occur in the same cycle, the byte wins: it is accepted and the timer clears.
- o_err is registered: high for exactly one cycle, the cycle after the causing edge. o_err_code updates in the same cycle that o_err is high.
- Latency: last data byte i_valid at edge N -> o_wr_valid high after edge N (visible in cycle N+1).
- Width: the timer is $clog2(p_timeout) bits and saturates by wrap to IDLE, so it never overflows. The byte count is 2 bits.
- o_wr_addr and o_wr_data keep their last values after the transfer; they are not cleared.

Decomposition:
- Package x_top_uart_loader_pkg holds:
  - enum loader_state_t {IDLE, ADDR, DATA, ISSUE};
  - enum loader_err_t {ERR_NONE=0, ERR_CMD=1, ERR_TIMEOUT=2, ERR_OVERRUN=3};
  - localparam byte count top = 3.
- One sub-module, x_top_timeout: a parameterised clear/enable counter with a terminal-count output, reusable by other UART blocks.
- The shift registers and state machine stay in the top.

Test Plan:
- Send A5, 78 56 34 12, EF BE AD DE with i_wr_ready=1 -> single o_wr_valid cycle with o_wr_addr=32'h12345678 and o_wr_data=32'hDEADBEEF; o_busy low afterwards.
- Same frame with i_wr_ready low for 10 cycles after o_wr_valid rises -> o_wr_valid held 11 cycles, address and data stable, exactly one transfer.
- Send byte 3C in IDLE -> o_err pulse for one cycle, o_err_code=1, state stays IDLE. A following valid frame is accepted normally.
- With p_timeout=16: send A5, 01, 02, then wait 16 cycles -> o_err with code 2 at the timeout, o_busy low. A new frame is accepted. Also send a byte exactly at timer=15 -> no error.
- Full frame with ready low, then send byte A5 during ISSUE, including a case where it coincides with the ready cycle -> o_err code 3, the byte is ignored, and the original transfer completes unchanged.
- Assert i_rst after A5 and two address bytes -> all outputs at reset values next cycle. A following clean frame yields the correct address with no stale bytes.
